// File: rtl/vdp_host_port_if.sv
// Host-side bus of the VDP: access request, address/data, byte strobes, read data and DTACK.
// The bridge (master) holds VDP_SEL until it sees VDP_DTACK_N low, then drops it.
interface vdp_host_port_if;
   logic        VDP_SEL;
   logic        VDP_RNW;
   logic [4:0]  VDP_A;
   logic [15:0] VDP_DI;
   logic        VDP_UDS_N;
   logic        VDP_LDS_N;
   logic [15:0] VDP_DO;
   logic        VDP_DTACK_N;

   modport master (
      output VDP_SEL, VDP_RNW, VDP_A, VDP_DI, VDP_UDS_N, VDP_LDS_N,
      input  VDP_DO, VDP_DTACK_N
   );

   modport slave (
      input  VDP_SEL, VDP_RNW, VDP_A, VDP_DI, VDP_UDS_N, VDP_LDS_N,
      output VDP_DO, VDP_DTACK_N
   );
endinterface

// File: rtl/vdp_host_port.sv
// VDP host port: data/control/status/HV decode, command latch, VRAM/CRAM/register writes.
// Define VDP_DMA_EN to compile in 68k-memory-to-VRAM DMA over the VBUS fetch port.
module vdp_host_port (
   input  logic                  clk,
   input  logic                  rst_n,
   vdp_host_port_if.slave        host,
   input  logic [15:0]           HV_count,
   input  logic                  vint_pend,
   input  logic                  vblank,
   input  logic                  hblank,
   output logic                  VDP_VBUS_SEL,
   output logic [22:0]           vbus_addr,
   input  logic [15:0]           VDP_VBUS_DATA,
   input  logic                  VDP_VBUS_DTACK_N,
   output logic                  vram_we,
   output logic                  vram_re,
   output logic [1:0]            vram_be,
   output logic [15:0]           vram_addr,
   output logic [15:0]           vram_wdata,
   input  logic [15:0]           vram_rdata,
   output logic                  cram_we,
   output logic [6:0]            cram_addr,
   output logic [15:0]           cram_wdata,
   output logic                  reg_we,
   output logic [4:0]            reg_num,
   output logic [7:0]            reg_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_WAIT, S_ACK, S_RELEASE, S_DMA_REQ, S_DMA_GAP
   } state_t;

   localparam logic [4:0] A_DATA = 5'b00000;
   localparam logic [4:0] A_CTRL = 5'b00100;
   localparam logic [4:0] A_HV   = 5'b01000;

   state_t      r_state;
   logic        r_pending;
   logic [5:0]  r_code;
   logic [15:0] r_addr;
   logic [7:0]  r_reg15;
   logic [15:0] r_do;
   logic        r_dtack_n;
   logic        r_rd_cap;
   logic        r_need_rel;
   logic        r_vram_we, r_vram_re, r_cram_we, r_reg_we;
   logic [1:0]  r_vram_be;
   logic [15:0] r_vram_addr, r_vram_wdata, r_cram_wdata;
   logic [6:0]  r_cram_addr;
   logic [4:0]  r_reg_num;
   logic [7:0]  r_reg_data;
   logic        r_dma_start;
   logic        r_dma_busy;
   logic        r_vbus_sel;
   logic [22:0] r_src;
   logic [15:0] r_len;
   logic [7:0]  r_reg1, r_reg19, r_reg20, r_reg21, r_reg22, r_reg23;

   logic [15:0] w_inc;
   logic        w_dma_busy;
   logic [15:0] w_status;
   logic        w_unused;

   assign w_inc    = {8'h00, r_reg15};
   assign w_status = {6'b0, 1'b1, 1'b0, vint_pend, 3'b0, vblank, hblank, w_dma_busy, 1'b0};

`ifdef VDP_DMA_EN
   assign w_dma_busy   = r_dma_busy;
   assign VDP_VBUS_SEL = r_vbus_sel;
   assign vbus_addr    = r_src;
   assign w_unused     = ^r_code[5:4];
`else
   assign w_dma_busy   = 1'b0;
   assign VDP_VBUS_SEL = 1'b0;
   assign vbus_addr    = 23'd0;
   assign w_unused     = ^{r_code[5:4], VDP_VBUS_DATA, VDP_VBUS_DTACK_N, r_dma_start, r_dma_busy,
                           r_vbus_sel, r_src, r_len, r_reg1, r_reg19, r_reg20, r_reg21, r_reg22,
                           r_reg23};
`endif

   // VRAM read data is forwarded straight through during its DTACK cycle, then held in r_do.
   assign host.VDP_DO      = r_rd_cap ? vram_rdata : r_do;
   assign host.VDP_DTACK_N = r_dtack_n;
   assign vram_we          = r_vram_we;
   assign vram_re          = r_vram_re;
   assign vram_be          = r_vram_be;
   assign vram_addr        = r_vram_addr;
   assign vram_wdata       = r_vram_wdata;
   assign cram_we          = r_cram_we;
   assign cram_addr        = r_cram_addr;
   assign cram_wdata       = r_cram_wdata;
   assign reg_we           = r_reg_we;
   assign reg_num          = r_reg_num;
   assign reg_data         = r_reg_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pending    <= 1'b0;
         r_code       <= 6'd0;
         r_addr       <= 16'd0;
         r_reg15      <= 8'd0;
         r_do         <= 16'd0;
         r_dtack_n    <= 1'b1;
         r_rd_cap     <= 1'b0;
         r_need_rel   <= 1'b0;
         r_vram_we    <= 1'b0;
         r_vram_re    <= 1'b0;
         r_cram_we    <= 1'b0;
         r_reg_we     <= 1'b0;
         r_vram_be    <= 2'b00;
         r_vram_addr  <= 16'd0;
         r_vram_wdata <= 16'd0;
         r_cram_addr  <= 7'd0;
         r_cram_wdata <= 16'd0;
         r_reg_num    <= 5'd0;
         r_reg_data   <= 8'd0;
         r_dma_start  <= 1'b0;
         r_dma_busy   <= 1'b0;
         r_vbus_sel   <= 1'b0;
         r_src        <= 23'd0;
         r_len        <= 16'd0;
         r_reg1       <= 8'd0;
         r_reg19      <= 8'd0;
         r_reg20      <= 8'd0;
         r_reg21      <= 8'd0;
         r_reg22      <= 8'd0;
         r_reg23      <= 8'd0;
      end else begin
         r_vram_we <= 1'b0;
         r_vram_re <= 1'b0;
         r_cram_we <= 1'b0;
         r_reg_we  <= 1'b0;
         if (!host.VDP_SEL) r_need_rel <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (host.VDP_SEL && !r_need_rel) begin
                  r_dtack_n <= 1'b0;
                  r_state   <= S_ACK;
                  case (host.VDP_A)
                     A_DATA: begin
                        r_pending <= 1'b0;
                        if (host.VDP_RNW) begin
                           if (r_code[3:0] == 4'b0000) begin
                              r_vram_re   <= 1'b1;
                              r_vram_addr <= r_addr;
                              r_addr      <= r_addr + w_inc;
                              r_dtack_n   <= 1'b1;
                              r_state     <= S_RD_WAIT;
                           end else begin
                              r_do <= 16'd0;
                           end
                        end else begin
                           if (r_code[3:0] == 4'b0001) begin
                              r_vram_we    <= 1'b1;
                              r_vram_addr  <= r_addr;
                              r_vram_be    <= ~{host.VDP_UDS_N, host.VDP_LDS_N};
                              r_vram_wdata <= host.VDP_DI;
                           end else if (r_code[3:0] == 4'b0011) begin
                              r_cram_we    <= 1'b1;
                              r_cram_addr  <= r_addr[7:1];
                              r_cram_wdata <= host.VDP_DI;
                           end
                           r_addr <= r_addr + w_inc;
                        end
                     end
                     A_CTRL: begin
                        if (host.VDP_RNW) begin
                           r_do      <= w_status;
                           r_pending <= 1'b0;
                        end else if (r_pending) begin
                           // Second command word: its top bits are not a register-write marker.
                           r_code[5:2]  <= host.VDP_DI[7:4];
                           r_addr[15:14] <= host.VDP_DI[1:0];
                           r_pending    <= 1'b0;
`ifdef VDP_DMA_EN
                           if (host.VDP_DI[7] && r_reg1[4] && !r_reg23[7]) begin
                              r_dma_start <= 1'b1;
                              r_dma_busy  <= 1'b1;
                              r_src       <= {r_reg23[6:0], r_reg22, r_reg21};
                              r_len       <= {r_reg20, r_reg19};
                           end
`endif
                        end else if (host.VDP_DI[15:14] == 2'b10) begin
                           r_reg_we   <= 1'b1;
                           r_reg_num  <= host.VDP_DI[12:8];
                           r_reg_data <= host.VDP_DI[7:0];
                           case (host.VDP_DI[12:8])
                              5'd15: r_reg15 <= host.VDP_DI[7:0];
`ifdef VDP_DMA_EN
                              5'd1:  r_reg1  <= host.VDP_DI[7:0];
                              5'd19: r_reg19 <= host.VDP_DI[7:0];
                              5'd20: r_reg20 <= host.VDP_DI[7:0];
                              5'd21: r_reg21 <= host.VDP_DI[7:0];
                              5'd22: r_reg22 <= host.VDP_DI[7:0];
                              5'd23: r_reg23 <= host.VDP_DI[7:0];
`endif
                              default: ;
                           endcase
                        end else begin
                           r_code[1:0]  <= host.VDP_DI[15:14];
                           r_addr[13:0] <= host.VDP_DI[13:0];
                           r_pending    <= 1'b1;
                        end
                     end
                     A_HV: begin
                        if (host.VDP_RNW) r_do <= HV_count;
                     end
                     default: begin
                        if (host.VDP_RNW) r_do <= 16'd0;
                     end
                  endcase
               end
            end
            S_RD_WAIT: begin
               r_dtack_n <= 1'b0;
               r_rd_cap  <= 1'b1;
               r_state   <= S_ACK;
            end
            S_ACK: begin
               r_dtack_n <= 1'b1;
               r_rd_cap  <= 1'b0;
               if (r_rd_cap) r_do <= vram_rdata;
               r_state <= S_RELEASE;
`ifdef VDP_DMA_EN
               // The host still holds SEL for the triggering write; it must drop before a new decode.
               if (r_dma_start) begin
                  r_dma_start <= 1'b0;
                  r_need_rel  <= 1'b1;
                  r_vbus_sel  <= 1'b1;
                  r_state     <= S_DMA_REQ;
               end
`endif
            end
            S_RELEASE: begin
               if (!host.VDP_SEL) r_state <= S_IDLE;
            end
`ifdef VDP_DMA_EN
            S_DMA_REQ: begin
               if (!VDP_VBUS_DTACK_N) begin
                  r_vbus_sel    <= 1'b0;
                  r_vram_we     <= 1'b1;
                  r_vram_addr   <= r_addr;
                  r_vram_be     <= 2'b11;
                  r_vram_wdata  <= VDP_VBUS_DATA;
                  r_addr        <= r_addr + w_inc;
                  r_src[15:0]   <= r_src[15:0] + 16'd1;
                  r_len         <= r_len - 16'd1;
                  r_state       <= S_DMA_GAP;
               end
            end
            S_DMA_GAP: begin
               if (r_len != 16'd0) begin
                  r_vbus_sel <= 1'b1;
                  r_state    <= S_DMA_REQ;
               end else begin
                  r_dma_busy <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vdp_host_port.sv
// Bench for vdp_host_port: host-bus driver, VRAM/VBUS responders, queue-based monitors.
`timescale 1ns/1ps
module tb_vdp_host_port;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vdp_host_port_if bus();

   logic [15:0] HV_count = 16'd0;
   logic        vint_pend = 1'b0, vblank = 1'b0, hblank = 1'b0;
   logic        VDP_VBUS_SEL;
   logic [22:0] vbus_addr;
   logic [15:0] VDP_VBUS_DATA = 16'd0;
   logic        VDP_VBUS_DTACK_N = 1'b1;
   logic        vram_we, vram_re;
   logic [1:0]  vram_be;
   logic [15:0] vram_addr, vram_wdata;
   logic [15:0] vram_rdata = 16'd0;
   logic        cram_we;
   logic [6:0]  cram_addr;
   logic [15:0] cram_wdata;
   logic        reg_we;
   logic [4:0]  reg_num;
   logic [7:0]  reg_data;

   vdp_host_port dut (
      .clk(clk), .rst_n(rst_n), .host(bus),
      .HV_count(HV_count), .vint_pend(vint_pend), .vblank(vblank), .hblank(hblank),
      .VDP_VBUS_SEL(VDP_VBUS_SEL), .vbus_addr(vbus_addr),
      .VDP_VBUS_DATA(VDP_VBUS_DATA), .VDP_VBUS_DTACK_N(VDP_VBUS_DTACK_N),
      .vram_we(vram_we), .vram_re(vram_re), .vram_be(vram_be), .vram_addr(vram_addr),
      .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
      .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
      .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] rd_q[$];   // host read data
   logic [33:0] vw_q[$];   // {addr, be, data}
   logic [15:0] vre_q[$];  // vram read address
   logic [22:0] cw_q[$];   // {cram_addr, data}
   logic [12:0] rw_q[$];   // {reg_num, reg_data}
   logic [22:0] vb_q[$];   // VBUS fetch address

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [127:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected event %h, expected none", name, act);
   endtask

   // Read-only VRAM contents for the read tests; one-cycle latency after vram_re.
   function automatic logic [15:0] vram_model(input logic [15:0] a);
      case (a)
         16'h0100: return 16'hBEEF;
         16'h0104: return 16'hCAFE;
         16'h010C: return 16'h1111;
         default:  return 16'hDEAD;
      endcase
   endfunction

   always @(posedge clk) begin
      if (vram_re === 1'b1) vram_rdata <= vram_model(vram_addr);
   end

   // VBUS responder: acknowledges on the second cycle SEL is seen high.
   int  vb_wait = 0;
   bit  vb_flagged = 0;
   always @(negedge clk) begin
      logic [22:0] e;
      if (VDP_VBUS_SEL === 1'b1 && VDP_VBUS_DTACK_N) begin
         if (vb_wait == 0) begin
            vb_wait = 1;
         end else begin
            vb_wait = 0;
            VDP_VBUS_DTACK_N = 1'b0;
            VDP_VBUS_DATA = vbus_addr[15:0] ^ 16'hA5A5;
            if (vb_q.size() == 0) begin
               if (!vb_flagged) unexpected("vbus_fetch", {105'd0, vbus_addr});
               vb_flagged = 1;
            end else begin
               e = vb_q.pop_front();
               check("vbus_addr", {105'd0, vbus_addr}, {105'd0, e});
            end
         end
      end else begin
         VDP_VBUS_DTACK_N = 1'b1;
         vb_wait = 0;
      end
   end

   // Monitors: every strobe or read DTACK pops one expectation.
   always @(negedge clk) begin
      logic [33:0] ev;
      logic [22:0] ec;
      logic [12:0] er;
      logic [15:0] ed;
      if (rst_n) begin
         if (vram_we === 1'b1) begin
            if (vw_q.size() == 0) unexpected("vram_we", {94'd0, vram_addr, vram_be, vram_wdata});
            else begin
               ev = vw_q.pop_front();
               check("vram_we", {94'd0, vram_addr, vram_be, vram_wdata}, {94'd0, ev});
            end
         end
         if (vram_re === 1'b1) begin
            if (vre_q.size() == 0) unexpected("vram_re", {112'd0, vram_addr});
            else begin
               ed = vre_q.pop_front();
               check("vram_re_addr", {112'd0, vram_addr}, {112'd0, ed});
            end
         end
         if (cram_we === 1'b1) begin
            if (cw_q.size() == 0) unexpected("cram_we", {105'd0, cram_addr, cram_wdata});
            else begin
               ec = cw_q.pop_front();
               check("cram_we", {105'd0, cram_addr, cram_wdata}, {105'd0, ec});
            end
         end
         if (reg_we === 1'b1) begin
            if (rw_q.size() == 0) unexpected("reg_we", {115'd0, reg_num, reg_data});
            else begin
               er = rw_q.pop_front();
               check("reg_we", {115'd0, reg_num, reg_data}, {115'd0, er});
            end
         end
         if (bus.VDP_DTACK_N === 1'b0 && bus.VDP_RNW === 1'b1) begin
            if (rd_q.size() == 0) unexpected("host_read", {112'd0, bus.VDP_DO});
            else begin
               ed = rd_q.pop_front();
               check("host_read_data", {112'd0, bus.VDP_DO}, {112'd0, ed});
            end
         end
      end
   end

   // exp_lat <= 0 skips the latency check (access deferred behind DMA).
   task automatic host_access(input logic rnw, input logic [4:0] a, input logic [15:0] di,
                              input logic [1:0] be_n, input int exp_lat, input int hold);
      int cyc;
      cyc = 0;
      @(negedge clk);
      bus.VDP_SEL = 1'b1;
      bus.VDP_RNW = rnw;
      bus.VDP_A = a;
      bus.VDP_DI = di;
      bus.VDP_UDS_N = be_n[1];
      bus.VDP_LDS_N = be_n[0];
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.VDP_DTACK_N !== 1'b0 && cyc < 300);
      if (bus.VDP_DTACK_N !== 1'b0) begin
         unexpected("dtack_timeout", 128'(cyc));
      end else if (exp_lat > 0) begin
         check("dtack_latency", 128'(cyc), 128'(exp_lat));
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("dtack_single_cycle", {127'd0, bus.VDP_DTACK_N}, 128'd1);
      end
      bus.VDP_SEL = 1'b0;
   endtask

   task automatic ctrl_wr(input logic [15:0] di);
      host_access(1'b0, 5'b00100, di, 2'b00, 1, 1);
   endtask

   task automatic reg_wr(input logic [15:0] di);
      rw_q.push_back({di[12:8], di[7:0]});
      ctrl_wr(di);
   endtask

   task automatic data_wr(input logic [15:0] di, input logic [1:0] be_n);
      host_access(1'b0, 5'b00000, di, be_n, 1, 1);
   endtask

   task automatic read_port(input logic [4:0] a, input logic [15:0] exp, input int lat, input int hold);
      rd_q.push_back(exp);
      host_access(1'b1, a, 16'h0000, 2'b00, lat, hold);
   endtask

   initial begin
      logic [114:0] rst_vec;
      logic [114:0] rst_exp;
      bus.VDP_SEL = 1'b0;
      bus.VDP_RNW = 1'b1;
      bus.VDP_A = 5'd0;
      bus.VDP_DI = 16'd0;
      bus.VDP_UDS_N = 1'b1;
      bus.VDP_LDS_N = 1'b1;
      repeat (3) @(negedge clk);
      rst_vec = {bus.VDP_DTACK_N, bus.VDP_DO, vram_we, vram_re, vram_be, vram_addr, vram_wdata,
                 cram_we, cram_addr, cram_wdata, reg_we, reg_num, reg_data, VDP_VBUS_SEL, vbus_addr};
      rst_exp = '0;
      rst_exp[114] = 1'b1;
      check("reset_outputs", {13'd0, rst_vec}, {13'd0, rst_exp});
      rst_n = 1'b1;

      // Register write, auto-increment 2
      reg_wr(16'h8F02);
      // VRAM write command at 0, two data writes
      ctrl_wr(16'h4000);
      ctrl_wr(16'h0000);
      vw_q.push_back({16'h0000, 2'b11, 16'h1234});
      data_wr(16'h1234, 2'b00);
      vw_q.push_back({16'h0002, 2'b11, 16'h5678});
      data_wr(16'h5678, 2'b00);

      // Address wrap: command at 0xFFFE, increment 4, low-byte-only write
      reg_wr(16'h8F04);
      ctrl_wr(16'h7FFE);
      ctrl_wr(16'h0003);
      vw_q.push_back({16'hFFFE, 2'b01, 16'hAAAA});
      data_wr(16'hAAAA, 2'b10);
      vw_q.push_back({16'h0002, 2'b11, 16'hBBBB});
      data_wr(16'hBBBB, 2'b00);

      // VRAM reads at 0x0100; SEL held long on the first one
      ctrl_wr(16'h0100);
      ctrl_wr(16'h0000);
      vre_q.push_back(16'h0100);
      read_port(5'b00000, 16'hBEEF, 2, 4);
      vre_q.push_back(16'h0104);
      read_port(5'b00000, 16'hCAFE, 2, 1);
      data_wr(16'h9999, 2'b00);
      vre_q.push_back(16'h010C);
      read_port(5'b00000, 16'h1111, 2, 1);

      // CRAM writes, then a data read with a non-read code returns 0
      ctrl_wr(16'hC010);
      ctrl_wr(16'h0000);
      cw_q.push_back({7'h08, 16'h0EEE});
      data_wr(16'h0EEE, 2'b00);
      cw_q.push_back({7'h0A, 16'h0123});
      data_wr(16'h0123, 2'b00);
      read_port(5'b00000, 16'h0000, 1, 1);

      // Status read clears pending; next 0x8114 is a register write
      vint_pend = 1'b1; vblank = 1'b0; hblank = 1'b1;
      ctrl_wr(16'h4000);
      read_port(5'b00100, 16'h0284, 1, 1);
      reg_wr(16'h8114);
      vint_pend = 1'b0; vblank = 1'b1; hblank = 1'b0;
      read_port(5'b00100, 16'h0208, 1, 1);
      vblank = 1'b0;

      // HV and unmapped ports
      HV_count = 16'h5A3C;
      host_access(1'b0, 5'b01000, 16'hFFFF, 2'b00, 1, 1);
      read_port(5'b01000, 16'h5A3C, 1, 1);
      host_access(1'b0, 5'b10000, 16'h8F07, 2'b00, 1, 1);
      read_port(5'b10000, 16'h0000, 1, 1);

      // DMA setup: length 3, source 0x00FFFF, increment 2, command 0x4000/0x0080
      reg_wr(16'h8110);
      reg_wr(16'h9303);
      reg_wr(16'h9400);
      reg_wr(16'h95FF);
      reg_wr(16'h96FF);
      reg_wr(16'h9700);
      reg_wr(16'h8F02);
      ctrl_wr(16'h4000);
`ifdef VDP_DMA_EN
      vb_q.push_back(23'h00FFFF);
      vb_q.push_back(23'h000000);
      vb_q.push_back(23'h000001);
      vw_q.push_back({16'h0000, 2'b11, 16'h5A5A});
      vw_q.push_back({16'h0002, 2'b11, 16'hA5A5});
      vw_q.push_back({16'h0004, 2'b11, 16'hA5A4});
      ctrl_wr(16'h0080);
      // Issued during DMA; serviced once it completes, with busy already clear
      read_port(5'b00100, 16'h0200, 0, 1);
      check("dma_words_done", 128'(vw_q.size() + vb_q.size()), 128'd0);
      vw_q.push_back({16'h0006, 2'b11, 16'h4444});
      data_wr(16'h4444, 2'b00);
`else
      ctrl_wr(16'h0080);
      vw_q.push_back({16'h0000, 2'b11, 16'h7777});
      data_wr(16'h7777, 2'b00);
      read_port(5'b00100, 16'h0200, 1, 1);
`endif

      repeat (6) @(negedge clk);
      check("leftover_expectations",
            128'(rd_q.size() + vw_q.size() + vre_q.size() + cw_q.size() + rw_q.size() + vb_q.size()),
            128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
